// File: rtl/ati_uart_tx.sv
// Byte FIFO feeding a UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Latency: a byte pushed at edge N is popped at edge N+1 if the line is idle; tx falls after that pop edge.
// Backpressure: device_available drops while the FIFO is full; strobes while full are dropped and set sticky overflow.
module ati_uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 434,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           device_data_in,
  input  logic                 device_wr_ins,
  output logic                 device_available,
  output logic                 device_idle,
  output logic                 tx,
  output logic [CNT_WIDTH-1:0] fifo_count,
  output logic                 overflow
);

  localparam int AW = CNT_WIDTH - 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0]        BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0]        BAUD_ONE  = BW'(1);
  localparam logic [CNT_WIDTH-1:0] PTR_ONE   = CNT_WIDTH'(1);
  // Index of the final stop bit; the stop counter only ever reaches 1 with two stop bits.
  localparam logic                 STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;

  logic                 full, empty, push, pop, bit_end;
  logic [7:0]           head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Push is judged on the pre-edge full flag, so a same-edge pop cannot make room for it.
  assign push    = device_wr_ins & ~full;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign bit_end = (baud_q == '0);

  assign device_available = ~full;
  assign device_idle      = empty & (state_q == S_IDLE);
  assign tx               = tx_q;
  assign fifo_count       = wr_ptr_q - rd_ptr_q;
  assign overflow         = overflow_q;

  // Serializer next-state: every bit lasts CLK_DIV cycles, the last stop bit may chain straight into a new start bit.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (device_wr_ins & full);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? BAUD_LAST : (baud_q - BAUD_ONE);
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head;
          state_d = S_START;
          tx_d    = 1'b0;
          baud_d  = BAUD_LAST;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = ^head;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              baud_d  = '0;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
      end
    endcase
  end

  // State registers; reset aborts any frame and flushes the FIFO by zeroing both pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= device_data_in;
  end

endmodule

// File: tb/tb_ati_uart_tx.sv
// Directed bench for ati_uart_tx: three instances cover plain, even-parity and two-stop-bit framing at CLK_DIV=4.
// Frames are captured cycle by cycle and compared against hand-built bit patterns; a small line receiver checks FIFO ordering.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
module tb_ati_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       wr;

  logic       tx_a, avail_a, idle_a, ovf_a;
  logic [4:0] cnt_a;
  logic       tx_p, avail_p, idle_p, ovf_p;
  logic [4:0] cnt_p;
  logic       tx_s, avail_s, idle_s, ovf_s;
  logic [4:0] cnt_s;

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;
  logic tx_sel, idle_sel;

  ati_uart_tx #(.FIFO_DEPTH(16), .CLK_DIV(4), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .device_data_in(data), .device_wr_ins(wr),
    .device_available(avail_a), .device_idle(idle_a), .tx(tx_a), .fifo_count(cnt_a), .overflow(ovf_a));
  ati_uart_tx #(.FIFO_DEPTH(16), .CLK_DIV(4), .PARITY_EN(1), .STOP_BITS(1)) u_p (
    .clk(clk), .rst_n(rst_n), .device_data_in(data), .device_wr_ins(wr),
    .device_available(avail_p), .device_idle(idle_p), .tx(tx_p), .fifo_count(cnt_p), .overflow(ovf_p));
  ati_uart_tx #(.FIFO_DEPTH(16), .CLK_DIV(4), .PARITY_EN(0), .STOP_BITS(2)) u_s (
    .clk(clk), .rst_n(rst_n), .device_data_in(data), .device_wr_ins(wr),
    .device_available(avail_s), .device_idle(idle_s), .tx(tx_s), .fifo_count(cnt_s), .overflow(ovf_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tx_sel   = tx_a;
    idle_sel = idle_a;
    if (sel == 1) begin
      tx_sel   = tx_p;
      idle_sel = idle_p;
    end else if (sel == 2) begin
      tx_sel   = tx_s;
      idle_sel = idle_s;
    end
  end

  // Line receiver for the plain instance: start detected on a low sample, bits sampled mid-bit.
  logic [7:0] mon_sh;
  logic       mon_busy;
  int         mon_cnt;
  int         stop_err;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy <= 1'b0;
      mon_cnt  <= 0;
    end else if (!mon_busy) begin
      if (tx_a == 1'b0) begin
        mon_busy <= 1'b1;
        mon_cnt  <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if ((mon_cnt % 4) == 2 && mon_cnt >= 6 && mon_cnt <= 34) mon_sh <= {tx_a, mon_sh[7:1]};
      if (mon_cnt == 38) begin
        mon_busy <= 1'b0;
        rxq.push_back(mon_sh);
        if (tx_a !== 1'b1) stop_err <= stop_err + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Samples nbits bit-times of the selected line starting now (first cycle of a start bit).
  task automatic capture(input int nbits, output logic [31:0] v, output int herr, output int idle_hi);
    logic first;
    v = '0;
    herr = 0;
    idle_hi = 0;
    first = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          first = tx_sel;
          v[b]  = first;
        end else if (tx_sel !== first) begin
          herr++;
        end
        if (idle_sel) idle_hi++;
        tick();
      end
    end
  endtask

  logic [31:0] v;
  int herr, idle_hi, low_cnt;

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    data  = 8'h00;
    stop_err = 0;
    do_reset();

    check("rst_tx",    tx_a,    1);
    check("rst_avail", avail_a, 1);
    check("rst_idle",  idle_a,  1);
    check("rst_count", cnt_a,   0);
    check("rst_ovf",   ovf_a,   0);

    // Single 0x55 frame, plain format
    sel  = 0;
    data = 8'h55;
    wr   = 1'b1;
    tick();
    wr = 1'b0;
    check("push_count", cnt_a, 1);
    check("push_tx_idle", tx_a, 1);
    check("push_idle_low", idle_a, 0);
    tick();
    check("pop_count", cnt_a, 0);
    capture(10, v, herr, idle_hi);
    check("frame_55", v, 32'h2AA);
    check("hold_55", herr, 0);
    check("idle_in_55", idle_hi, 0);
    check("idle_after_55", idle_a, 1);
    check("tx_after_55", tx_a, 1);

    // Even parity: 0x07 (parity 1) then 0x03 (parity 0), back to back
    do_reset();
    sel  = 1;
    data = 8'h07;
    wr   = 1'b1;
    tick();
    check("par_count1", cnt_p, 1);
    data = 8'h03;
    tick();
    wr = 1'b0;
    check("par_count_pushpop", cnt_p, 1);
    capture(22, v, herr, idle_hi);
    check("frame_par", v, 32'h0020360E);
    check("hold_par", herr, 0);
    check("idle_in_par", idle_hi, 0);
    check("idle_after_par", idle_p, 1);

    // Two frames back to back, 0xA5 then 0x3C
    do_reset();
    sel  = 0;
    data = 8'hA5;
    wr   = 1'b1;
    tick();
    data = 8'h3C;
    tick();
    wr = 1'b0;
    capture(20, v, herr, idle_hi);
    check("frame_a53c", v, 32'h0009E34A);
    check("hold_a53c", herr, 0);
    check("idle_in_a53c", idle_hi, 0);
    check("idle_after_a53c", idle_a, 1);

    // Two stop bits: 0xFF then 0x00
    do_reset();
    sel  = 2;
    data = 8'hFF;
    wr   = 1'b1;
    tick();
    data = 8'h00;
    tick();
    wr = 1'b0;
    capture(22, v, herr, idle_hi);
    check("frame_stop2", v, 32'h003007FE);
    check("hold_stop2", herr, 0);
    check("idle_after_stop2", idle_s, 1);

    // Fill to full while busy, drop one strobe, drain and compare order
    sel = 0;
    do_reset();
    rxq.delete();
    stop_err = 0;
    wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data = 8'h10 + 8'(i);
      tick();
    end
    check("full_count", cnt_a, 16);
    check("full_avail", avail_a, 0);
    check("full_ovf_clear", ovf_a, 0);
    data = 8'hEE;
    tick();
    wr = 1'b0;
    check("drop_count", cnt_a, 16);
    check("drop_ovf", ovf_a, 1);
    repeat (17 * 40 + 10) tick();
    check("drain_idle", idle_a, 1);
    check("drain_ovf_sticky", ovf_a, 1);
    check("drain_frames", rxq.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < rxq.size()) check($sformatf("drain_byte%0d", i), rxq[i], 8'h10 + 8'(i));
    end
    check("drain_stop_err", stop_err, 0);

    // Reset during data bit 3 with three bytes queued
    do_reset();
    rxq.delete();
    wr = 1'b1;
    data = 8'hF7;
    tick();
    data = 8'h11;
    tick();
    data = 8'h22;
    tick();
    data = 8'h33;
    tick();
    wr = 1'b0;
    check("rstmid_queued", cnt_a, 3);
    repeat (15) tick();
    check("rstmid_bit3", tx_a, 0);
    rst_n = 1'b0;
    tick();
    check("rstmid_tx", tx_a, 1);
    check("rstmid_count", cnt_a, 0);
    check("rstmid_idle", idle_a, 1);
    check("rstmid_ovf", ovf_a, 0);
    rst_n = 1'b1;
    rxq.delete();
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_a !== 1'b1) low_cnt++;
      tick();
    end
    check("rstmid_quiet", low_cnt, 0);
    check("rstmid_no_frames", rxq.size(), 0);
    check("rstmid_idle_after", idle_a, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ati_uart_tx.md
# ati_uart_tx

Byte-stream consumer sitting directly downstream of the ATI slave bus interface: it accepts the byte strobes the interface produces on its device port, buffers them in a FIFO, and serializes them onto a UART TX line (LSB first, start bit, optional even parity, 1 or 2 stop bits). It drives the `device_available` and `device_idle` signals that throttle the interface's byte drain.

## Interface
- `FIFO_DEPTH`, 16: byte FIFO entries; power of 2, ≥ 2.
- `CLK_DIV`, 434: clk cycles per UART bit; ≥ 2.
- `PARITY_EN`, 0: 1 = append even parity bit after data.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `CNT_WIDTH`, $clog2(FIFO_DEPTH)+1: width of `fifo_count`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `device_data_in`  in  8  byte from the bus interface (its device data output).
- `device_wr_ins`  in  1  byte strobe; one push per cycle sampled high.
- `device_available`  out  1  FIFO not full.
- `device_idle`  out  1  FIFO empty and serializer in IDLE.
- `tx`  out  1  UART line, idle high; registered.
- `fifo_count`  out  CNT_WIDTH  bytes currently held (0..FIFO_DEPTH).
- `overflow`  out  1  sticky: a strobe arrived while full.

## Operation
- Reset values: `tx`=1, `device_available`=1, `device_idle`=1, `fifo_count`=0, `overflow`=0; pointers 0, state IDLE, baud counter 0.
- FIFO: read/write pointers CNT_WIDTH bits wide (extra wrap bit); full = MSBs differ, low bits equal; empty = pointers equal. Pointers wrap naturally at FIFO_DEPTH.
- Push: `device_wr_ins`=1 and not full at the sampling edge → store byte, advance write pointer. Strobe while full → byte dropped, `overflow` set (held until reset).
- Pop: serializer in IDLE (or finishing last stop bit) and FIFO not empty → read head byte into shift register, advance read pointer.
- Simultaneous push and pop: both occur, count unchanged. When full, push is judged on pre-edge full flag → rejected even if a pop happens the same edge.
- `device_available` = ~full, `device_idle` = empty & state==IDLE, both combinational from registered state.
- Serializer FSM: IDLE → START → DATA (8 bits, LSB first) → PARITY (only if PARITY_EN) → STOP (STOP_BITS bit times) → IDLE, or directly → START if FIFO non-empty at end of last stop bit.
- Parity bit = XOR of the 8 data bits (even parity).
- Baud counter: loaded with CLK_DIV-1 on entering each bit, decrements each cycle; bit ends when counter=0.

## Timing
- Byte pushed at edge N → `fifo_count` increments after N. If serializer IDLE, pop at edge N+1, `tx` goes 0 (start) after N+1.
- Every bit, including start and stop, holds `tx` for exactly CLK_DIV cycles.
- Frame length = (10 + PARITY_EN + STOP_BITS − 1) × CLK_DIV cycles.
- Back-to-back bytes: start bit of next frame begins the cycle after last stop bit ends; zero idle gap.
- `fifo_count` decrements the cycle after the pop edge (the cycle `tx` falls).
- `device_idle` rises the cycle after the last stop bit completes with FIFO empty.
- Reset mid-frame: at the reset edge frame aborts, FIFO flushed, `tx`=1 from the next cycle; no partial byte retransmitted.

## Test plan
- CLK_DIV=4, PARITY_EN=0, push 0x55 → `tx` = 0,1,0,1,0,1,0,1,0,1 bits each 4 cycles (start 0, data LSB first 1,0,1,0,1,0,1,0, stop 1); `device_idle` 0 during frame, 1 after 40 cycles.
- PARITY_EN=1, push 0x07 → parity bit 1 after data; push 0x03 → parity bit 0; frame 44 cycles at CLK_DIV=4.
- Push 16 bytes back-to-back while `tx` busy → `fifo_count`=16, `device_available`=0; 17th strobe dropped, `overflow`=1; subsequently transmitted bytes match first 16 in order.
- Push 0xA5, 0x3C consecutively → second start bit immediately follows first stop bit, no gap; total 80 cycles at CLK_DIV=4, STOP_BITS=1.
- STOP_BITS=2, push 0xFF → stop high for 2×CLK_DIV, next frame start delayed accordingly.
- Assert `rst_n`=0 mid data bit 3 with 3 bytes queued → next cycle `tx`=1, `fifo_count`=0, `device_idle`=1, `overflow`=0; no further frames after release.
